// File: rtl/eth_tx_pkt_arbiter.sv
// Packet-granular arbiter sharing one MAC TX byte stream among FWFT byte sources,
// with inter-packet gap and runaway-packet truncation. Define ARB_STRICT_PRIO_EN for strict priority.
module eth_tx_pkt_arbiter #(
  parameter int P_NUM_REQ       = 3,
  parameter int P_IPG_CYCLES    = 12,
  parameter int P_MAX_PKT_BYTES = 1514
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_arst_n,
  input  logic [P_NUM_REQ-1:0][7:0] i_req_byte,
  input  logic [P_NUM_REQ-1:0]      i_req_byte_vld,
  input  logic [P_NUM_REQ-1:0]      i_req_last_byte,
  output logic [P_NUM_REQ-1:0]      o_req_byte_rd,
  output logic [7:0]                o_pkt_byte,
  output logic                      o_pkt_byte_vld,
  output logic                      o_pkt_last_byte,
  input  logic                      i_pkt_byte_rd,
  output logic [P_NUM_REQ-1:0]      o_grant,
  output logic                      o_busy,
  output logic                      o_pkt_len_error
);

  localparam int GNT_W    = $clog2(P_NUM_REQ);
  localparam int CNT_W    = $clog2(P_MAX_PKT_BYTES + 1);
  localparam int IPG_W    = (P_IPG_CYCLES > 0) ? $clog2(P_IPG_CYCLES + 1) : 1;
  localparam int IPG_LAST = (P_IPG_CYCLES > 0) ? P_IPG_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_MAX_PKT_BYTES - 1);
  localparam logic [GNT_W-1:0] IDX_LAST = GNT_W'(P_NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_FLUSH, S_IPG} state_t;
  localparam state_t POST_PKT = (P_IPG_CYCLES == 0) ? S_IDLE : S_IPG;

  state_t           state, state_nxt;
  logic [GNT_W-1:0] gnt_idx, pick_idx, rr_ptr;
  logic             pick_vld;
  logic [CNT_W-1:0] byte_cnt;
  logic [IPG_W-1:0] ipg_cnt;
  logic             cur_vld, cur_last, pop, pkt_done, trunc;

  assign cur_vld  = i_req_byte_vld[gnt_idx];
  assign cur_last = i_req_last_byte[gnt_idx];
  assign o_busy   = (state != S_IDLE);

`ifdef ARB_STRICT_PRIO_EN
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_byte_vld[i]) begin
        pick_vld = 1'b1;
        pick_idx = GNT_W'(i);
      end
    end
  end
`else
  int rr_idx;

  // Descending scan over offsets from rr_ptr: the nearest valid requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_idx   = 0;
    for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
      rr_idx = int'(rr_ptr) + i;
      if (rr_idx >= P_NUM_REQ) rr_idx = rr_idx - P_NUM_REQ;
      if (i_req_byte_vld[rr_idx]) begin
        pick_vld = 1'b1;
        pick_idx = GNT_W'(rr_idx);
      end
    end
  end
`endif

  always_ff @(posedge i_sys_clk or negedge i_sys_arst_n) begin
    if (!i_sys_arst_n) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    o_req_byte_rd   = '0;
    o_pkt_byte      = '0;
    o_pkt_byte_vld  = 1'b0;
    o_pkt_last_byte = 1'b0;
    o_grant         = '0;
    pop             = 1'b0;
    pkt_done        = 1'b0;
    trunc           = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_vld) state_nxt = S_XFER;
      end
      S_XFER: begin
        o_grant[gnt_idx]       = 1'b1;
        o_pkt_byte             = i_req_byte[gnt_idx];
        o_pkt_byte_vld         = cur_vld;
        o_pkt_last_byte        = cur_last | (byte_cnt == CNT_LAST);
        pop                    = i_pkt_byte_rd & cur_vld;
        o_req_byte_rd[gnt_idx] = pop;
        if (pop) begin
          if (cur_last) begin
            pkt_done  = 1'b1;
            state_nxt = POST_PKT;
          end else if (byte_cnt == CNT_LAST) begin
            trunc     = 1'b1;
            state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Drain the remainder of an over-long packet without presenting it downstream.
        o_grant[gnt_idx]       = 1'b1;
        o_req_byte_rd[gnt_idx] = cur_vld;
        if (cur_vld && cur_last) begin
          pkt_done  = 1'b1;
          state_nxt = POST_PKT;
        end
      end
      S_IPG: begin
        if (ipg_cnt == IPG_W'(IPG_LAST)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_arst_n) begin
    if (!i_sys_arst_n) begin
      gnt_idx         <= '0;
      rr_ptr          <= '0;
      byte_cnt        <= '0;
      ipg_cnt         <= '0;
      o_pkt_len_error <= 1'b0;
    end else begin
      o_pkt_len_error <= trunc;
      if (state == S_IDLE && pick_vld) gnt_idx <= pick_idx;
      if (state == S_XFER) begin
        if (pop) byte_cnt <= byte_cnt + CNT_W'(1);
      end else begin
        byte_cnt <= '0;
      end
      if (state == S_IPG) ipg_cnt <= ipg_cnt + IPG_W'(1);
      else                ipg_cnt <= '0;
`ifdef ARB_STRICT_PRIO_EN
      rr_ptr <= '0;
`else
      if (pkt_done) rr_ptr <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + GNT_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// Randomized bench for eth_tx_pkt_arbiter: per-cycle behavioural model plus literal packet-level checks.
module tb_eth_tx_pkt_arbiter;

  localparam int N   = 3;
  localparam int IPG = 12;
  localparam int MAX = 1514;
`ifdef ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif
  localparam int M_IDLE = 0, M_SEND = 1, M_DRAIN = 2, M_GAP = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0][7:0] i_req_byte = '0;
  logic [N-1:0]      i_req_byte_vld = '0;
  logic [N-1:0]      i_req_last_byte = '0;
  logic [N-1:0]      o_req_byte_rd;
  logic [7:0]        o_pkt_byte;
  logic              o_pkt_byte_vld, o_pkt_last_byte;
  logic              i_pkt_byte_rd = 1'b0;
  logic [N-1:0]      o_grant;
  logic              o_busy, o_pkt_len_error;

  eth_tx_pkt_arbiter #(.P_NUM_REQ(N), .P_IPG_CYCLES(IPG), .P_MAX_PKT_BYTES(MAX)) dut (
    .i_sys_clk(clk), .i_sys_arst_n(rst_n),
    .i_req_byte(i_req_byte), .i_req_byte_vld(i_req_byte_vld), .i_req_last_byte(i_req_last_byte),
    .o_req_byte_rd(o_req_byte_rd),
    .o_pkt_byte(o_pkt_byte), .o_pkt_byte_vld(o_pkt_byte_vld), .o_pkt_last_byte(o_pkt_last_byte),
    .i_pkt_byte_rd(i_pkt_byte_rd),
    .o_grant(o_grant), .o_busy(o_busy), .o_pkt_len_error(o_pkt_len_error)
  );

  always #5 clk = ~clk;

  // Source FIFOs: {last, byte} per entry
  logic [8:0] src_q [N][$];
  bit stall_en = 1'b0, rd_rand = 1'b0;

  // Reference model state
  int m_phase, m_g, m_rr, m_cnt, m_gap;
  bit m_err_pend;

  // Observed packet-level facts
  int pkt_src[$], pkt_len[$];
  int cur_len, err_obs, flush_obs, ipg_obs, first_vld, cyc_in_test;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic push_pkt(input int s, input int len);
    for (int b = 1; b <= len; b++)
      src_q[s].push_back({(b == len), 8'($urandom_range(255))});
  endtask

  task automatic clear_obs();
    pkt_src.delete(); pkt_len.delete();
    cur_len = 0; err_obs = 0; flush_obs = 0; ipg_obs = 0; first_vld = -1; cyc_in_test = 0;
  endtask

  task automatic finish_pkt();
    m_rr = STRICT ? 0 : (m_g + 1) % N;
    if (IPG > 0) begin m_phase = M_GAP; m_gap = IPG; end
    else m_phase = M_IDLE;
  endtask

  task automatic cycle_body();
    logic [N-1:0] vis, e_grant, e_rd;
    logic [7:0] e_byte;
    logic e_vld, e_last, e_busy, e_err, hl;
    int pick, idx;
    vis = '0;
    for (int i = 0; i < N; i++) begin
      vis[i] = (src_q[i].size() > 0) && !(stall_en && ($urandom_range(3) == 0));
      i_req_byte_vld[i] = vis[i];
      if (src_q[i].size() > 0) begin
        i_req_byte[i]      = src_q[i][0][7:0];
        i_req_last_byte[i] = src_q[i][0][8];
      end else begin
        i_req_byte[i]      = 8'h00;
        i_req_last_byte[i] = 1'b0;
      end
    end
    i_pkt_byte_rd = rd_rand ? 1'($urandom_range(1)) : 1'b1;
    #1;
    // Expected outputs for this cycle
    e_grant = '0; e_rd = '0; e_vld = 1'b0; e_last = 1'b0; e_byte = '0;
    e_busy = (m_phase != M_IDLE);
    e_err  = m_err_pend;
    if (m_phase == M_SEND || m_phase == M_DRAIN) e_grant[m_g] = 1'b1;
    if (m_phase == M_SEND) begin
      e_vld = vis[m_g];
      if (src_q[m_g].size() > 0) begin
        e_byte = src_q[m_g][0][7:0];
        e_last = src_q[m_g][0][8] || (m_cnt == MAX - 1);
      end
      e_rd[m_g] = i_pkt_byte_rd && vis[m_g];
    end
    if (m_phase == M_DRAIN) e_rd[m_g] = vis[m_g];
    chk("pkt_vld", 32'(o_pkt_byte_vld), 32'(e_vld));
    chk("grant", 32'(o_grant), 32'(e_grant));
    chk("busy", 32'(o_busy), 32'(e_busy));
    chk("req_rd", 32'(o_req_byte_rd), 32'(e_rd));
    chk("len_err", 32'(o_pkt_len_error), 32'(e_err));
    if (e_vld) begin
      chk("pkt_byte", 32'(o_pkt_byte), 32'(e_byte));
      chk("pkt_last", 32'(o_pkt_last_byte), 32'(e_last));
    end
    // Observation of DUT behaviour
    if (o_pkt_byte_vld && first_vld < 0) first_vld = cyc_in_test;
    if (o_pkt_byte_vld && i_pkt_byte_rd) begin
      cur_len++;
      if (o_pkt_last_byte) begin
        pkt_src.push_back(onehot_idx(o_grant));
        pkt_len.push_back(cur_len);
        cur_len = 0;
      end
    end
    if (o_pkt_len_error) err_obs++;
    if (|o_req_byte_rd && !o_pkt_byte_vld) flush_obs++;
    if (o_busy && o_grant == '0) ipg_obs++;
    cyc_in_test++;
    // Advance the model
    m_err_pend = 1'b0;
    case (m_phase)
      M_IDLE: if (|vis) begin
        pick = 0;
        for (int k = N - 1; k >= 0; k--) begin
          idx = STRICT ? k : (m_rr + k) % N;
          if (vis[idx]) pick = idx;
        end
        m_g = pick; m_cnt = 0; m_phase = M_SEND;
      end
      M_SEND: if (i_pkt_byte_rd && vis[m_g]) begin
        hl = src_q[m_g][0][8];
        void'(src_q[m_g].pop_front());
        m_cnt++;
        if (hl) finish_pkt();
        else if (m_cnt == MAX) begin m_phase = M_DRAIN; m_err_pend = 1'b1; end
      end
      M_DRAIN: if (vis[m_g]) begin
        hl = src_q[m_g][0][8];
        void'(src_q[m_g].pop_front());
        if (hl) finish_pkt();
      end
      default: begin
        m_gap--;
        if (m_gap == 0) m_phase = M_IDLE;
      end
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    cycle_body();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_vld", 32'(o_pkt_byte_vld), 0);
    chk("rst_byte", 32'(o_pkt_byte), 0);
    chk("rst_last", 32'(o_pkt_last_byte), 0);
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_rd", 32'(o_req_byte_rd), 0);
    chk("rst_err", 32'(o_pkt_len_error), 0);
    m_phase = M_IDLE; m_rr = 0; m_cnt = 0; m_gap = 0; m_g = 0; m_err_pend = 1'b0;
    repeat (2) @(negedge clk);
    clear_obs();
    rst_n = 1'b1;
    cycle_body();
  endtask

  task automatic run_idle(input int budget);
    int c = 0;
    while (!(m_phase == M_IDLE && src_q[0].size() == 0 && src_q[1].size() == 0 &&
             src_q[2].size() == 0) && c < budget) begin
      cycle();
      c++;
    end
    if (c >= budget) begin
      miscompares++;
      $display("FAIL run_idle: timeout after %0d cycles", c);
    end
    repeat (2) cycle();
  endtask

  initial begin
    int exp_order[9];
    int c;
    m_phase = M_IDLE; m_rr = 0; m_cnt = 0; m_gap = 0; m_g = 0; m_err_pend = 1'b0;
    clear_obs();

    // T1: single 60-byte packet from requester 1
    push_pkt(1, 60);
    apply_reset();
    run_idle(500);
    chk("t1_npkt", 32'(pkt_src.size()), 1);
    if (pkt_src.size() > 0) begin
      chk("t1_src", 32'(pkt_src[0]), 1);
      chk("t1_len", 32'(pkt_len[0]), 60);
    end
    chk("t1_first_vld", 32'(first_vld), 1);
    chk("t1_ipg", 32'(ipg_obs), 12);

    // T2: three requesters with three packets each, all valid together
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < N; s++) push_pkt(s, 5 + $urandom_range(25));
    apply_reset();
    run_idle(2000);
    if (STRICT) exp_order = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    else        exp_order = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    chk("t2_npkt", 32'(pkt_src.size()), 9);
    for (int k = 0; k < 9; k++)
      if (k < pkt_src.size()) chk($sformatf("t2_order%0d", k), 32'(pkt_src[k]), 32'(exp_order[k]));

    // T3: 1600-byte runaway packet from requester 2
    push_pkt(2, 1600);
    apply_reset();
    run_idle(3000);
    chk("t3_npkt", 32'(pkt_len.size()), 1);
    if (pkt_len.size() > 0) chk("t3_len", 32'(pkt_len[0]), 1514);
    chk("t3_err_pulses", 32'(err_obs), 1);
    chk("t3_flushed", 32'(flush_obs), 86);
    chk("t3_ipg", 32'(ipg_obs), 12);

    // T4: packet of exactly the limit
    push_pkt(0, 1514);
    apply_reset();
    run_idle(3000);
    if (pkt_len.size() > 0) chk("t4_len", 32'(pkt_len[0]), 1514);
    chk("t4_err_pulses", 32'(err_obs), 0);
    chk("t4_flushed", 32'(flush_obs), 0);

    // T5: random downstream backpressure, source gaps and packet arrivals
    apply_reset();
    rd_rand = 1'b1; stall_en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      push_pkt($urandom_range(N - 1), 1 + $urandom_range(39));
      repeat ($urandom_range(30)) cycle();
    end
    run_idle(20000);
    rd_rand = 1'b0; stall_en = 1'b0;

    // T6: reset asserted mid-transfer after 20 bytes, round-robin pointer left at 2 beforehand
    apply_reset();
    push_pkt(1, 5);
    run_idle(500);
    push_pkt(1, 80);
    c = 0;
    while (!(m_phase == M_SEND && m_cnt == 20) && c < 200) begin cycle(); c++; end
    chk("t6_reach_byte20", 32'(m_cnt), 20);
    push_pkt(2, 10);
    apply_reset();
    run_idle(1000);
    chk("t6_npkt", 32'(pkt_src.size()), 2);
    if (pkt_src.size() > 1) begin
      chk("t6_first_src", 32'(pkt_src[0]), 1);
      chk("t6_first_len", 32'(pkt_len[0]), 60);
      chk("t6_second_src", 32'(pkt_src[1]), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
